// File: rtl/otter_intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_intc_pkg
//  Description : Shared definitions for the OTTER interrupt controller.
//                Holds the IOBUS register word offsets and the controller
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package otter_intc_pkg;

    // Byte offsets of each register from BASE_ADDR
    localparam logic [4:0] OFF_PENDING  = 5'h00;
    localparam logic [4:0] OFF_ENABLE   = 5'h04;
    localparam logic [4:0] OFF_MODE     = 5'h08;
    localparam logic [4:0] OFF_ID       = 5'h0C;
    localparam logic [4:0] OFF_COMPLETE = 5'h10;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } intc_state_e;

endpackage : otter_intc_pkg
`default_nettype wire

// File: rtl/intc_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : intc_prio_enc
//  Description : Combinational fixed-priority encoder. The lowest set index
//                of req_i wins.
//  Ports       : req_i   [N-1:0]  request vector
//                valid_o          at least one request bit set
//                idx_o   [4:0]    index of the lowest set bit (0 when none)
//  Revision    : 1.0  initial release
// ============================================================================
module intc_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [4:0]   idx_o
);

    // Scan from the top down so the lowest set index is the last to assign.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 5'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 5'(i);
            end
        end
    end

endmodule : intc_prio_enc
`default_nettype wire

// File: rtl/otter_intr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : otter_intr_ctrl
//  Description : Multi-source interrupt controller for the OTTER CPU.
//                Synchronises up to 32 sources, supports per-source enable
//                and level/edge mode, arbitrates by fixed priority (lowest
//                index wins) and runs a claim/complete handshake over IOBUS.
//  Ports       : clk         system clock
//                RST         asynchronous active-low reset
//                SRC         raw asynchronous interrupt sources
//                IOBUS_ADDR  CPU IOBUS byte address
//                IOBUS_OUT   CPU IOBUS write data
//                IOBUS_WR    CPU IOBUS write strobe
//                RD_DATA     combinational read data (0 outside the window)
//                RD_HIT      address lies in the register window
//                INTR        interrupt request to the CPU
//  Revision    : 1.0  initial release
// ============================================================================
module otter_intr_ctrl
    import otter_intc_pkg::*;
#(
    parameter int          N_SRC     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_SRC-1:0] SRC,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      RD_DATA,
    output logic             RD_HIT,
    output logic             INTR
);

    // ------------------------------------------------------------------
    // Synchroniser and edge-detect flops
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] s1_q;
    logic [N_SRC-1:0] s_q;
    logic [N_SRC-1:0] sd_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_q <= '0;
            s_q  <= '0;
            sd_q <= '0;
        end else begin
            s1_q <= SRC;
            s_q  <= s1_q;
            sd_q <= s_q;
        end
    end

    // ------------------------------------------------------------------
    // IOBUS decode
    // ------------------------------------------------------------------
    logic [4:0] off;
    logic       wr_pending;
    logic       wr_enable;
    logic       wr_mode;
    logic       wr_complete;

    assign off    = IOBUS_ADDR[4:0];
    assign RD_HIT = (IOBUS_ADDR[31:5] == BASE_ADDR[31:5]) &&
                    (off <= OFF_COMPLETE) && (off[1:0] == 2'b00);

    assign wr_pending  = IOBUS_WR && RD_HIT && (off == OFF_PENDING);
    assign wr_enable   = IOBUS_WR && RD_HIT && (off == OFF_ENABLE);
    assign wr_mode     = IOBUS_WR && RD_HIT && (off == OFF_MODE);
    assign wr_complete = IOBUS_WR && RD_HIT && (off == OFF_COMPLETE);

    // ------------------------------------------------------------------
    // Pending / enable / mode
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] mode_q,   mode_d;
    logic [N_SRC-1:0] edge_q,   edge_d;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] edge_set;
    logic [N_SRC-1:0] edge_clr;
    logic [N_SRC-1:0] cur_onehot;

    intc_state_e state_q, state_d;
    logic [4:0]  cur_id_q, cur_id_d;
    logic        complete_hit;
    logic        win_valid;
    logic [4:0]  win_idx;
    logic        cur_req;

    // Level channels read the third flop so level and edge requests reach
    // the arbiter with the same latency. Edge bits are held at zero while a
    // channel is in level mode, so a later switch to edge mode never
    // inherits stale state.
    assign pend     = (mode_q & edge_q) | (~mode_q & sd_q);
    assign req      = pend & enable_q;
    assign edge_set = mode_q & s_q & ~sd_q;

    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cur_onehot[i] = (cur_id_q == 5'(i));
        end
    end

    assign cur_req      = |(req & cur_onehot);
    assign complete_hit = wr_complete && (state_q == REQ) &&
                          (IOBUS_OUT == (32'(cur_id_q) + 32'd1));

    assign edge_clr = (wr_pending   ? IOBUS_OUT[N_SRC-1:0] : '0) |
                      (complete_hit ? cur_onehot           : '0);

    // A new edge in the same cycle as a clear keeps the bit set.
    assign edge_d   = mode_q & (edge_set | (edge_q & ~edge_clr));
    assign enable_d = wr_enable ? IOBUS_OUT[N_SRC-1:0] : enable_q;
    assign mode_d   = wr_mode   ? IOBUS_OUT[N_SRC-1:0] : mode_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            edge_q   <= '0;
            enable_q <= '0;
            mode_q   <= '0;
        end else begin
            edge_q   <= edge_d;
            enable_q <= enable_d;
            mode_q   <= mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration and claim/complete FSM
    // ------------------------------------------------------------------
    intc_prio_enc #(
        .N (N_SRC)
    ) u_prio (
        .req_i   (req),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cur_id_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cur_id_q <= cur_id_d;
        end
    end

    // CUR_ID only loads on IDLE->REQ, so a higher-priority arrival while in
    // REQ waits for the next pass through IDLE.
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = REQ;
                    cur_id_d = win_idx;
                end
            end
            REQ: begin
                if (complete_hit) begin
                    state_d = HOLD;
                end else if (!cur_req) begin
                    state_d = IDLE;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign INTR = (state_q == REQ);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        RD_DATA = 32'd0;
        if (RD_HIT) begin
            case (off)
                OFF_PENDING: RD_DATA[N_SRC-1:0] = pend;
                OFF_ENABLE:  RD_DATA[N_SRC-1:0] = enable_q;
                OFF_MODE:    RD_DATA[N_SRC-1:0] = mode_q;
                OFF_ID:      RD_DATA = (state_q == REQ) ? (32'(cur_id_q) + 32'd1) : 32'd0;
                default:     RD_DATA = 32'd0;
            endcase
        end
    end

endmodule : otter_intr_ctrl
`default_nettype wire
